// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-N up/down counter with clear, clamped load, wrap/saturate mode and cascade tc.
module mod_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
  generate
    if (MODULUS < 2 || MODULUS > 2 ** WIDTH || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad
      $error("mod_updown_counter: illegal MODULUS/RESET_VAL for WIDTH");
    end
  endgenerate
  logic             at_bound;
  logic             over;
  logic [WIDTH-1:0] step;
  always_comb begin
    at_bound = up ? (count == MAX) : (count == '0);
    over     = {1'b0, load_val} >= MOD_W;
    step     = up ? (at_bound ? ((SATURATE != 0) ? count : '0) : count + 1'b1)
                  : (at_bound ? ((SATURATE != 0) ? count : MAX) : count - 1'b1);
    tc       = en & ~rst & ~clr & ~load & at_bound;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= RST_V;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= over ? MAX : load_val;
      if (over) ovf <= 1'b1;
    end else if (en) begin
      count <= step;
      if (at_bound) ovf <= 1'b1;
    end
  end
endmodule
